// File: rtl/usb2_ep_pkg.sv
// Shared state encoding, endpoint geometry and round-robin helper for the
// USB 2.0 IN endpoint sequencer.
package usb2_ep_pkg;

    localparam int unsigned EP_LEN_W    = 11;
    localparam int unsigned EP_HALF_BUF = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StCommit,
        StAckLow,
        StZlpWait
    } ep_state_e;

    // Pointer to the requester after cur, wrapping at nreq.
    function automatic logic [2:0] rr_next(input logic [2:0] cur, input int unsigned nreq);
        return ((32'(cur) + 1) >= nreq) ? 3'd0 : cur + 3'd1;
    endfunction

endpackage

// File: rtl/usb2_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching circularly. The parent registers the result.
module usb2_rr_arb #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      idx,
    output logic            any
);

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] cand;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        masked = req & hi_mask;
        // Nothing at or above ptr: wrap and take the lowest request overall.
        cand = (|masked) ? masked : req;
        gnt  = '0;
        idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = 3'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/usb2_ep_in_arb.sv
// Round-robin packetiser sharing one double-buffered USB 2.0 IN endpoint among
// NREQ byte streams. Define USB2_EP_IN_ZLP_EN to append a zero-length packet.
module usb2_ep_in_arb
    import usb2_ep_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned MAX_PKT     = 512,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                phy_clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     grant,
    output logic [EP_LEN_W-1:0] buf_in_addr,
    output logic [7:0]          buf_in_data,
    output logic                buf_in_wren,
    input  logic                buf_in_ready,
    output logic                buf_in_commit,
    output logic [EP_LEN_W-1:0] buf_in_commit_len,
    input  logic                buf_in_commit_ack,
    output logic                pkt_done,
    output logic [2:0]          pkt_src,
    output logic                err_timeout
);

    localparam int unsigned TO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(ACK_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [EP_LEN_W-1:0] PKT_MAX =
        EP_LEN_W'((MAX_PKT > EP_HALF_BUF) ? EP_HALF_BUF : MAX_PKT);
`ifdef USB2_EP_IN_ZLP_EN
    localparam bit ZLP_EN = 1'b1;
`else
    localparam bit ZLP_EN = 1'b0;
`endif

    ep_state_e           state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [2:0]          owner_q, owner_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [2:0]          src_q, src_d;
    logic [EP_LEN_W-1:0] cnt_q, cnt_d;
    logic [EP_LEN_W-1:0] addr_q, addr_d;
    logic [EP_LEN_W-1:0] len_q, len_d;
    logic [7:0]          data_q, data_d;
    logic                wren_q, wren_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                zlp_q, zlp_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

    logic [NREQ-1:0]     arb_gnt;
    logic [2:0]          arb_idx;
    logic                arb_any;
    logic [7:0]          sel_byte;
    logic                sel_last;
    logic                accept;
    logic [EP_LEN_W-1:0] cnt_inc;

    usb2_rr_arb #(
        .NREQ(NREQ)
    ) u_rr_arb (
        .req(req_valid),
        .ptr(rr_ptr_q),
        .gnt(arb_gnt),
        .idx(arb_idx),
        .any(arb_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) sel_byte = req_data[8*i +: 8];
        end
    end

    assign sel_last = |(req_last & grant_q);
    assign accept   = (state_q == StFill) && |(req_valid & grant_q);
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        src_d    = src_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        len_d    = len_q;
        wren_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        zlp_d    = zlp_q;
        to_cnt_d = to_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (buf_in_ready && arb_any) begin
                    grant_d = arb_gnt;
                    owner_d = arb_idx;
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (accept) begin
                    data_d = sel_byte;
                    addr_d = cnt_q;
                    wren_d = 1'b1;
                    cnt_d  = cnt_inc;
                    if (sel_last || (cnt_inc == PKT_MAX)) begin
                        len_d    = cnt_inc;
                        to_cnt_d = '0;
                        zlp_d    = ZLP_EN && sel_last && (cnt_inc == PKT_MAX);
                        state_d  = StCommit;
                    end
                end
            end
            StCommit: begin
                // Timeout is only reported; the endpoint is still waited for.
                if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
                if (to_cnt_q == TO_LAST) err_d = 1'b1;
                if (buf_in_commit_ack) state_d = StAckLow;
            end
            StAckLow: begin
                if (!buf_in_commit_ack) begin
                    done_d = 1'b1;
                    src_d  = owner_q;
                    if (zlp_q) begin
                        zlp_d   = 1'b0;
                        state_d = StZlpWait;
                    end else begin
                        grant_d  = '0;
                        rr_ptr_d = rr_next(owner_q, NREQ);
                        state_d  = StIdle;
                    end
                end
            end
            StZlpWait: begin
                if (buf_in_ready) begin
                    len_d    = '0;
                    to_cnt_d = '0;
                    state_d  = StCommit;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            src_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            len_q    <= '0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            zlp_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            len_q    <= len_d;
            wren_q   <= wren_d;
            done_q   <= done_d;
            err_q    <= err_d;
            zlp_q    <= zlp_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign req_ready         = (state_q == StFill) ? grant_q : '0;
    assign grant             = grant_q;
    assign buf_in_addr       = addr_q;
    assign buf_in_data       = data_q;
    assign buf_in_wren       = wren_q;
    assign buf_in_commit     = (state_q == StCommit);
    assign buf_in_commit_len = len_q;
    assign pkt_done          = done_q;
    assign pkt_src           = src_q;
    assign err_timeout       = err_q;

endmodule

// File: tb/tb_usb2_ep_in_arb.sv
// Directed bench for usb2_ep_in_arb: per-requester byte sources, an endpoint
// responder and a write/commit/done scoreboard.
module tb_usb2_ep_in_arb;

    localparam int unsigned NREQ        = 4;
    localparam int unsigned MAX_PKT     = 512;
    localparam int unsigned ACK_TIMEOUT = 255;

    logic              phy_clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [10:0]       buf_in_addr;
    logic [7:0]        buf_in_data;
    logic              buf_in_wren;
    logic              buf_in_ready;
    logic              buf_in_commit;
    logic [10:0]       buf_in_commit_len;
    logic              buf_in_commit_ack;
    logic              pkt_done;
    logic [2:0]        pkt_src;
    logic              err_timeout;

    always #5 phy_clk = ~phy_clk;

    usb2_ep_in_arb #(
        .NREQ(NREQ),
        .MAX_PKT(MAX_PKT),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .phy_clk(phy_clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .buf_in_addr(buf_in_addr),
        .buf_in_data(buf_in_data),
        .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready),
        .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len),
        .buf_in_commit_ack(buf_in_commit_ack),
        .pkt_done(pkt_done),
        .pkt_src(pkt_src),
        .err_timeout(err_timeout)
    );

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  srcq [NREQ][$];
    logic [18:0] exp_wr[$];
    logic [10:0] exp_len[$];
    logic [2:0]  exp_src[$];
    logic [10:0] obs_len[$];
    logic [2:0]  obs_src[$];
    logic [NREQ-1:0] fire = '0;
    int unsigned pkt_cnt = 0;
    logic        commit_prev = 1'b0;
    logic [10:0] len_at_rise = '0;
    logic        ack_auto = 1'b1;
    logic        ack_manual = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected endpoint traffic for one accepted byte from requester src.
    task automatic model_accept(input int src, input logic [8:0] ent);
        exp_wr.push_back({11'(pkt_cnt), ent[7:0]});
        pkt_cnt++;
        if (ent[8] || pkt_cnt == MAX_PKT) begin
            exp_len.push_back(11'(pkt_cnt));
            exp_src.push_back(3'(src));
`ifdef USB2_EP_IN_ZLP_EN
            if (ent[8] && pkt_cnt == MAX_PKT) begin
                exp_len.push_back(11'd0);
                exp_src.push_back(3'(src));
            end
`endif
            pkt_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge phy_clk);
        #2;
    endtask

    function automatic bit busy();
        bit b = (exp_wr.size() != 0) || (exp_len.size() != 0) || (exp_src.size() != 0);
        for (int i = 0; i < NREQ; i++) b = b || (srcq[i].size() != 0);
        return b || (grant != '0) || buf_in_commit;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, 32'(n < budget), 32'd1);
        repeat (2) tick();
    endtask

    task automatic load(input int src, input int nbytes, input int base);
        logic [8:0] ent;
        for (int k = 0; k < nbytes; k++) begin
            ent = {1'(k == nbytes - 1), 8'(base + k)};
            srcq[src].push_back(ent);
        end
    endtask

    // Requester sources: present queue heads, retire them on handshake.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge phy_clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (fire[i]) begin
                    model_accept(i, srcq[i][0]);
                    void'(srcq[i].pop_front());
                end
                if (srcq[i].size() != 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = srcq[i][0][7:0];
                    req_last[i]         = srcq[i][0][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    // Endpoint responder: ack follows commit unless held manually.
    initial begin
        buf_in_commit_ack = 1'b0;
        forever begin
            @(posedge phy_clk);
            #1;
            buf_in_commit_ack = ack_auto ? buf_in_commit : ack_manual;
        end
    end

    always @(negedge phy_clk) begin
        fire = req_valid & req_ready & {NREQ{reset_n}};
        chk("grant_onehot", 32'($onehot0(grant)), 32'd1);
        chk("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
        if (buf_in_wren) begin
            chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) chk("wr_addr_data", {buf_in_addr, buf_in_data},
                                        exp_wr.pop_front());
        end
        if (buf_in_commit && !commit_prev) begin
            chk("len_expected", 32'(exp_len.size() != 0), 32'd1);
            if (exp_len.size() != 0) chk("commit_len", buf_in_commit_len, exp_len.pop_front());
            obs_len.push_back(buf_in_commit_len);
            len_at_rise = buf_in_commit_len;
        end else if (buf_in_commit) begin
            chk("len_stable", buf_in_commit_len, len_at_rise);
        end
        if (pkt_done) begin
            chk("done_expected", 32'(exp_src.size() != 0), 32'd1);
            if (exp_src.size() != 0) chk("pkt_src", pkt_src, exp_src.pop_front());
            obs_src.push_back(pkt_src);
        end
        commit_prev = buf_in_commit;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  ord2[4];
        logic [2:0]  ord4[5];
        logic [10:0] len4[5];
        int          n;
        reset_n      = 1'b0;
        buf_in_ready = 1'b1;
        repeat (3) tick();
        chk("rst_grant", grant, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wren", buf_in_wren, 0);
        chk("rst_addr", buf_in_addr, 0);
        chk("rst_data", buf_in_data, 0);
        chk("rst_commit", buf_in_commit, 0);
        chk("rst_len", buf_in_commit_len, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_src", pkt_src, 0);
        chk("rst_err", err_timeout, 0);
        reset_n = 1'b1;
        tick();

        // Five-byte packet from requester 0.
        load(0, 5, 8'hA0);
        drain("a", 200);
        chk("a_count", obs_src.size(), 1);
        chk("a_src", obs_src[0], 0);
        chk("a_len", obs_len[0], 5);

        // Requesters 1 and 2 valid from reset: strict alternation.
        obs_src.delete();
        obs_len.delete();
        reset_n = 1'b0;
        load(1, 3, 8'h10);
        load(1, 3, 8'h13);
        load(2, 3, 8'h20);
        load(2, 3, 8'h23);
        tick();
        reset_n = 1'b1;
        drain("rr", 400);
        ord2 = '{3'd1, 3'd2, 3'd1, 3'd2};
        chk("rr_count", obs_src.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), obs_src[i], ord2[i]);

        // Long stream split at MAX_PKT, interleaved with requester 3.
        obs_src.delete();
        obs_len.delete();
        load(0, 1030, 0);
        load(3, 2, 8'h30);
        load(3, 2, 8'h32);
        drain("big", 4000);
        ord4 = '{3'd3, 3'd0, 3'd3, 3'd0, 3'd0};
        len4 = '{11'd2, 11'd512, 11'd2, 11'd512, 11'd6};
        chk("big_count", obs_src.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("big_src%0d", i), obs_src[i], ord4[i]);
            chk($sformatf("big_len%0d", i), obs_len[i], len4[i]);
        end

        // Ack withheld: sticky timeout flag, packet still completes.
        obs_src.delete();
        obs_len.delete();
        ack_auto   = 1'b0;
        ack_manual = 1'b0;
        load(1, 3, 8'h40);
        n = 0;
        while (!buf_in_commit && n < 100) begin
            tick();
            n++;
        end
        chk("tmo_commit_seen", 32'(buf_in_commit), 32'd1);
        repeat (ACK_TIMEOUT - 1) tick();
        chk("tmo_before", err_timeout, 0);
        tick();
        chk("tmo_set", err_timeout, 1);
        chk("tmo_still_commit", buf_in_commit, 1);
        repeat (44) tick();
        ack_auto = 1'b1;
        drain("tmo", 100);
        chk("tmo_sticky", err_timeout, 1);
        chk("tmo_len", obs_len[0], 3);

        // No grant while the endpoint has no free buffer.
        buf_in_ready = 1'b0;
        load(2, 1, 8'h5A);
        repeat (6) tick();
        chk("noready_grant", grant, 0);
        chk("noready_ready", req_ready, 0);
        buf_in_ready = 1'b1;
        drain("noready", 100);
        chk("noready_src", obs_src[obs_src.size() - 1], 2);

        // Reset at byte 100 of a packet; the rest restarts at address 0.
        obs_src.delete();
        obs_len.delete();
        load(0, 150, 7);
        n = 0;
        while (pkt_cnt < 100 && n < 400) begin
            tick();
            n++;
        end
        chk("mid_reached", pkt_cnt, 100);
        reset_n = 1'b0;
        pkt_cnt = 0;
        tick();
        chk("mid_commit", buf_in_commit, 0);
        chk("mid_wren", buf_in_wren, 0);
        chk("mid_grant", grant, 0);
        chk("mid_err", err_timeout, 0);
        reset_n = 1'b1;
        drain("mid", 400);
        chk("mid_count", obs_len.size(), 1);
        chk("mid_len", obs_len[0], 50);

        // Last byte coincides with MAX_PKT.
        obs_src.delete();
        obs_len.delete();
        load(0, 512, 3);
        drain("max", 1500);
`ifdef USB2_EP_IN_ZLP_EN
        chk("max_count", obs_len.size(), 2);
        chk("max_len0", obs_len[0], 512);
        chk("max_len1", obs_len[1], 0);
        chk("max_src1", obs_src[1], 0);
`else
        chk("max_count", obs_len.size(), 1);
        chk("max_len0", obs_len[0], 512);
`endif
        chk("max_src0", obs_src[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
